regfile_write_scheduler: RTL and testbench

Shares the single register-file write port between N_REQ writeback sources (ALU result, load data, multiply/divide unit) using round-robin arbitration, and drives a registered write onto the register file's write port. It also keeps a per-register pending-write scoreboard: decode reserves a destination register at issue, and the scheduler reports read hazards on the two register-file read indices. It sits between the execute/memory writeback sources and the register file, alongside decode's stall logic.

---
 rtl/regfile_sched_pkg.sv | 21 ++
 rtl/regfile_write_scheduler_rr_arbiter.sv | 33 +++
 rtl/regfile_write_scheduler.sv | 126 ++++++++++++
 tb/tb_regfile_write_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write scheduler and its arbiter.
package regfile_sched_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int DATA_W    = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic              valid;
    reg_idx_t          dst_reg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Pointer width for an N-way round-robin; a 1-way arbiter still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (mod N) and grants the first request found.
module rr_arbiter
  import regfile_sched_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]            req,
  input  logic [ptr_width(N)-1:0] ptr,
  output logic [N-1:0]            grant
);

  localparam int PTR_W = ptr_width(N);

  always_comb begin
    int                 pos;
    logic               found;
    logic [PTR_W-1:0]   idx;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = PTR_W'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port among N_REQ writeback sources and tracks
// pending writes per register so decode can detect read hazards.
module regfile_write_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int CNT_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [REG_IDX_W*N_REQ-1:0] req_reg,
  input  logic [DATA_W*N_REQ-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       rsv_valid,
  input  logic [REG_IDX_W-1:0]       rsv_reg,
  output logic                       rsv_ready,
  input  logic [REG_IDX_W-1:0]       read_index1,
  input  logic [REG_IDX_W-1:0]       read_index2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic                       write_enable,
  output logic [REG_IDX_W-1:0]       write_reg,
  output logic [DATA_W-1:0]          write_data,
  output logic [NUM_REGS-1:0]        pending_mask
);

  localparam int               PTR_W   = ptr_width(N_REQ);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_req_t           reqs [N_REQ];
  logic [PTR_W-1:0]  last_grant;
  logic              sel_valid;
  logic [PTR_W-1:0]  sel_idx;
  reg_idx_t          sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic [CNT_W-1:0]    count [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                rsv_fire;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      reqs[i].valid   = req_valid[i];
      reqs[i].dst_reg = req_reg[REG_IDX_W*i +: REG_IDX_W];
      reqs[i].data    = req_data[DATA_W*i +: DATA_W];
    end
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (last_grant),
    .grant (req_ready)
  );

  // Grant is one-hot, so the winner's fields can be selected directly.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_reg   = '0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i] && reqs[i].valid) begin
        sel_valid = 1'b1;
        sel_idx   = PTR_W'(i);
        sel_reg   = reqs[i].dst_reg;
        sel_data  = reqs[i].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= PTR_RST;
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else if (sel_valid) begin
      last_grant   <= sel_idx;
      write_enable <= (sel_reg != '0);
      write_reg    <= sel_reg;
      write_data   <= sel_data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // A saturated counter still accepts a reservation when its write retires this cycle.
  assign rsv_ready = (rsv_reg == '0) ||
                     (count[rsv_reg] != CNT_MAX) ||
                     (write_enable && (write_reg == rsv_reg));
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_reg != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_vec[r] = rsv_fire && (rsv_reg == REG_IDX_W'(r));
      dec_vec[r] = write_enable && (write_reg == REG_IDX_W'(r));
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset || r == 0) begin
        count[r] <= '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        count[r] <= count[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r] && count[r] != '0) begin
        count[r] <= count[r] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (count[r] != '0);
    end
  end

  assign hazard1 = (read_index1 != '0) && (count[read_index1] != '0);
  assign hazard2 = (read_index2 != '0) && (count[read_index2] != '0);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: arbitration, writeback latency and scoreboard.
module tb_regfile_write_scheduler;

  localparam int N_REQ = 3;
  localparam int CNT_W = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [5*N_REQ-1:0]  req_reg;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                rsv_valid;
  logic [4:0]          rsv_reg;
  logic                rsv_ready;
  logic [4:0]          read_index1, read_index2;
  logic                hazard1, hazard2;
  logic                write_enable;
  logic [4:0]          write_reg;
  logic [31:0]         write_data;
  logic [31:0]         pending_mask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_reg      (req_reg),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsv_valid    (rsv_valid),
    .rsv_reg      (rsv_reg),
    .rsv_ready    (rsv_ready),
    .read_index1  (read_index1),
    .read_index2  (read_index2),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .pending_mask (pending_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_reg   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    read_index1 = 5'd0;
    read_index2 = 5'd0;
    reset = 1'b1;
    tick();
    req_valid = 3'b110;
    req_reg[9:5] = 5'd3;
    #1;
    tests++;
    if (req_ready !== 3'b010) begin
      fails++; $display("FAIL reset_ready: got %b want %b", req_ready, 3'b010);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (write_enable !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      fails++; $display("FAIL reset_outputs: we=%b reg=%0d data=%h want 0/0/0", write_enable, write_reg, write_data);
    end
    tests++;
    if (pending_mask !== 32'd0 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      fails++; $display("FAIL reset_scoreboard: mask=%h hz=%b%b want 0", pending_mask, hazard1, hazard2);
    end
    reset = 1'b0;
  endtask

  task automatic test_reserve_write();
    rsv_valid = 1'b1;
    rsv_reg   = 5'd5;
    #1;
    tests++;
    if (rsv_ready !== 1'b1) begin
      fails++; $display("FAIL rsv5_ready: got %b want 1", rsv_ready);
    end
    tick();
    rsv_valid   = 1'b0;
    read_index1 = 5'd5;
    #1;
    tests++;
    if (hazard1 !== 1'b1 || pending_mask !== 32'h0000_0020) begin
      fails++; $display("FAIL rsv5_hazard: hz=%b mask=%h want 1/00000020", hazard1, pending_mask);
    end
    req_valid       = 3'b010;
    req_reg[9:5]    = 5'd5;
    req_data[63:32] = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (req_ready !== 3'b010) begin
      fails++; $display("FAIL wr5_grant: got %b want 010", req_ready);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (write_enable !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEAD_BEEF || hazard1 !== 1'b1) begin
      fails++; $display("FAIL wr5_emit: we=%b reg=%0d data=%h hz=%b want 1/5/deadbeef/1", write_enable, write_reg, write_data, hazard1);
    end
    tick();
    tests++;
    if (write_enable !== 1'b0 || hazard1 !== 1'b0 || pending_mask !== 32'd0) begin
      fails++; $display("FAIL wr5_retire: we=%b hz=%b mask=%h want 0/0/0", write_enable, hazard1, pending_mask);
    end
    read_index1 = 5'd0;
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < N_REQ; i++) begin
      req_reg[5*i +: 5]   = 5'(i + 1);
      req_data[32*i +: 32] = 32'h1000 + 32'(i);
    end
    for (int k = 0; k < 6; k++) begin
      logic [2:0] exp_gnt;
      exp_gnt = 3'b001 << (k % 3);
      #1;
      tests++;
      if (req_ready !== exp_gnt) begin
        fails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_gnt);
      end
      tick();
      tests++;
      if (write_enable !== 1'b1 || write_reg !== 5'(k % 3 + 1) || write_data !== 32'h1000 + 32'(k % 3)) begin
        fails++; $display("FAIL rr_write[%0d]: we=%b reg=%0d data=%h want 1/%0d/%h", k, write_enable, write_reg, write_data, k % 3 + 1, 32'h1000 + 32'(k % 3));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reg0();
    req_valid       = 3'b001;
    req_reg[4:0]    = 5'd0;
    req_data[31:0]  = 32'h1234;
    rsv_valid       = 1'b1;
    rsv_reg         = 5'd0;
    #1;
    tests++;
    if (req_ready !== 3'b001 || rsv_ready !== 1'b1) begin
      fails++; $display("FAIL r0_ready: req_ready=%b rsv_ready=%b want 001/1", req_ready, rsv_ready);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (write_enable !== 1'b0 || pending_mask !== 32'd0) begin
      fails++; $display("FAIL r0_write: we=%b mask=%h want 0/0", write_enable, pending_mask);
    end
  endtask

  task automatic test_saturate();
    rsv_valid = 1'b1;
    rsv_reg   = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (rsv_ready !== 1'b1) begin
        fails++; $display("FAIL sat_rsv[%0d]: got %b want 1", k, rsv_ready);
      end
      tick();
    end
    #1;
    tests++;
    if (rsv_ready !== 1'b0 || pending_mask !== 32'h0000_0080) begin
      fails++; $display("FAIL sat_full: rsv_ready=%b mask=%h want 0/00000080", rsv_ready, pending_mask);
    end
    rsv_valid      = 1'b0;
    req_valid      = 3'b001;
    req_reg[4:0]   = 5'd7;
    req_data[31:0] = 32'h0000_0077;
    tick();
    idle_inputs();
    rsv_valid = 1'b1;
    rsv_reg   = 5'd7;
    #1;
    tests++;
    if (write_enable !== 1'b1 || write_reg !== 5'd7 || rsv_ready !== 1'b1) begin
      fails++; $display("FAIL sat_overlap: we=%b reg=%0d rsv_ready=%b want 1/7/1", write_enable, write_reg, rsv_ready);
    end
    tick();
    #1;
    tests++;
    if (write_enable !== 1'b0 || rsv_ready !== 1'b0) begin
      fails++; $display("FAIL sat_still3: we=%b rsv_ready=%b want 0/0", write_enable, rsv_ready);
    end
    rsv_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    rsv_valid   = 1'b1;
    rsv_reg     = 5'd9;
    read_index2 = 5'd9;
    tick();
    rsv_valid = 1'b0;
    #1;
    tests++;
    if (hazard2 !== 1'b1) begin
      fails++; $display("FAIL mid_hazard: got %b want 1", hazard2);
    end
    req_valid        = 3'b100;
    req_reg[14:10]   = 5'd9;
    req_data[95:64]  = 32'h9999_0009;
    reset            = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    tests++;
    if (write_enable !== 1'b0 || pending_mask !== 32'd0 || hazard2 !== 1'b0) begin
      fails++; $display("FAIL mid_reset: we=%b mask=%h hz2=%b want 0/0/0", write_enable, pending_mask, hazard2);
    end
    read_index2 = 5'd0;
  endtask

  task automatic test_unreserved();
    read_index1    = 5'd4;
    req_valid      = 3'b001;
    req_reg[4:0]   = 5'd4;
    req_data[31:0] = 32'h4444_0004;
    tick();
    idle_inputs();
    #1;
    tests++;
    if (write_enable !== 1'b1 || write_reg !== 5'd4 || write_data !== 32'h4444_0004 || pending_mask[4] !== 1'b0) begin
      fails++; $display("FAIL unrsv_write: we=%b reg=%0d data=%h pend4=%b want 1/4/44440004/0", write_enable, write_reg, write_data, pending_mask[4]);
    end
    tick();
    tests++;
    if (pending_mask !== 32'd0 || hazard1 !== 1'b0) begin
      fails++; $display("FAIL unrsv_count: mask=%h hz=%b want 0/0", pending_mask, hazard1);
    end
    rsv_valid      = 1'b1;
    rsv_reg        = 5'd4;
    req_valid      = 3'b001;
    req_reg[4:0]   = 5'd4;
    req_data[31:0] = 32'h4444_0044;
    tick();
    idle_inputs();
    #1;
    tests++;
    if (write_enable !== 1'b1 || pending_mask !== 32'h0000_0010 || hazard1 !== 1'b1) begin
      fails++; $display("FAIL rsvwr_pending: we=%b mask=%h hz=%b want 1/00000010/1", write_enable, pending_mask, hazard1);
    end
    tick();
    tests++;
    if (pending_mask !== 32'd0 || hazard1 !== 1'b0) begin
      fails++; $display("FAIL rsvwr_retire: mask=%h hz=%b want 0/0", pending_mask, hazard1);
    end
  endtask

  initial begin
    test_reset();
    test_reserve_write();
    test_round_robin();
    test_reg0();
    test_saturate();
    test_reset_mid();
    test_unreserved();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
